// File: rtl/uart_transceiver_param.sv
// Parametrised full-duplex UART: valid/ready transmitter plus mid-bit sampling receiver with parity/framing checks.
// Optional internal loopback (LOOPBACK port) is compiled in when UART_LOOPBACK_EN is defined.
module uart_transceiver_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              UART_CLK,
  input  logic              UART_RST_N,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic              TX_SERIAL,
  output logic              TX_BUSY,
`ifdef UART_LOOPBACK_EN
  input  logic              LOOPBACK,
`endif
  input  logic              RX_SERIAL,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  output logic              RX_PARITY_ERR,
  output logic              RX_FRAME_ERR,
  output logic              RX_BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY_MODE != 0);
  localparam logic             ODD_PAR   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_PARITY, TXS_STOP} tx_state_t;
  typedef enum logic [2:0] {RXS_IDLE, RXS_START, RXS_DATA, RXS_PARITY, RXS_STOP, RXS_WAIT_IDLE} rx_state_t;

  // Reset asserts asynchronously but releases two clocks later, aligned to UART_CLK.
  logic r_rst_meta, r_rst_sync;
  logic w_rst_n;

  // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
  always_ff @(posedge UART_CLK or negedge UART_RST_N) begin
    if (!UART_RST_N) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end
  assign w_rst_n = r_rst_sync;

  // ---------------- Transmitter ----------------
  tx_state_t         r_tx_state, w_tx_state_nxt;
  logic [CNT_W-1:0]  r_tx_cnt, w_tx_cnt_nxt;
  logic [IDX_W-1:0]  r_tx_idx, w_tx_idx_nxt;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
  logic              r_tx_par, w_tx_par_nxt;
  logic              w_tx_bit;
  logic              w_rx_in;

  always_ff @(posedge UART_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_tx_state <= TXS_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_idx   <= w_tx_idx_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_idx_nxt   = r_tx_idx;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    w_tx_bit       = 1'b1;
    case (r_tx_state)
      TXS_IDLE: begin
        if (TX_VALID) begin
          w_tx_state_nxt = TXS_START;
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_shift_nxt = TX_DATA;
          w_tx_par_nxt   = (^TX_DATA) ^ ODD_PAR;
        end
      end
      TXS_START: begin
        w_tx_bit = 1'b0;
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_state_nxt = TXS_DATA;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      TXS_DATA: begin
        w_tx_bit = r_tx_shift[0];
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_shift_nxt = {1'b0, r_tx_shift[DATA_W-1:1]};
          if (r_tx_idx == IDX_LAST) begin
            w_tx_idx_nxt   = '0;
            w_tx_state_nxt = HAS_PAR ? TXS_PARITY : TXS_STOP;
          end else begin
            w_tx_idx_nxt = r_tx_idx + IDX_W'(1);
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      TXS_PARITY: begin
        w_tx_bit = r_tx_par;
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt   = '0;
          w_tx_idx_nxt   = '0;
          w_tx_state_nxt = TXS_STOP;
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      TXS_STOP: begin
        if (r_tx_cnt == CNT_LAST) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_idx == STOP_LAST) begin
            w_tx_idx_nxt   = '0;
            w_tx_state_nxt = TXS_IDLE;
          end else begin
            w_tx_idx_nxt = r_tx_idx + IDX_W'(1);
          end
        end else begin
          w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
        end
      end
      default: w_tx_state_nxt = TXS_IDLE;
    endcase
  end

  assign TX_READY = (r_tx_state == TXS_IDLE);
  assign TX_BUSY  = (r_tx_state != TXS_IDLE);

`ifdef UART_LOOPBACK_EN
  assign TX_SERIAL = LOOPBACK ? 1'b1 : w_tx_bit;
  assign w_rx_in   = LOOPBACK ? w_tx_bit : RX_SERIAL;
`else
  assign TX_SERIAL = w_tx_bit;
  assign w_rx_in   = RX_SERIAL;
`endif

  // ---------------- Receiver ----------------
  logic              r_rx_sync1, r_rx_sync2;
  logic              w_rx;
  rx_state_t         r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0]  r_rx_cnt, w_rx_cnt_nxt;
  logic [IDX_W-1:0]  r_rx_idx, w_rx_idx_nxt;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
  logic              r_rx_par_bit, w_rx_par_bit_nxt;
  logic [DATA_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_rx_perr, w_rx_perr_nxt;
  logic              r_rx_ferr, w_rx_ferr_nxt;

  always_ff @(posedge UART_CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_sync1   <= 1'b1;
      r_rx_sync2   <= 1'b1;
      r_rx_state   <= RXS_IDLE;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bit <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
    end else begin
      r_rx_sync1   <= w_rx_in;
      r_rx_sync2   <= r_rx_sync1;
      r_rx_state   <= w_rx_state_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_rx_idx     <= w_rx_idx_nxt;
      r_rx_shift   <= w_rx_shift_nxt;
      r_rx_par_bit <= w_rx_par_bit_nxt;
      r_rx_data    <= w_rx_data_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_rx_perr    <= w_rx_perr_nxt;
      r_rx_ferr    <= w_rx_ferr_nxt;
    end
  end
  assign w_rx = r_rx_sync2;

  // START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    w_rx_state_nxt   = r_rx_state;
    w_rx_cnt_nxt     = r_rx_cnt;
    w_rx_idx_nxt     = r_rx_idx;
    w_rx_shift_nxt   = r_rx_shift;
    w_rx_par_bit_nxt = r_rx_par_bit;
    w_rx_data_nxt    = r_rx_data;
    w_rx_valid_nxt   = 1'b0;
    w_rx_perr_nxt    = r_rx_perr;
    w_rx_ferr_nxt    = r_rx_ferr;
    case (r_rx_state)
      RXS_IDLE: begin
        if (!w_rx) begin
          w_rx_state_nxt = RXS_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RXS_START: begin
        if (r_rx_cnt == CNT_HALF) begin
          w_rx_cnt_nxt   = '0;
          w_rx_idx_nxt   = '0;
          w_rx_state_nxt = w_rx ? RXS_IDLE : RXS_DATA;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RXS_DATA: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {w_rx, r_rx_shift[DATA_W-1:1]};
          if (r_rx_idx == IDX_LAST) begin
            w_rx_idx_nxt   = '0;
            w_rx_state_nxt = HAS_PAR ? RXS_PARITY : RXS_STOP;
          end else begin
            w_rx_idx_nxt = r_rx_idx + IDX_W'(1);
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RXS_PARITY: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt     = '0;
          w_rx_par_bit_nxt = w_rx;
          w_rx_state_nxt   = RXS_STOP;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RXS_STOP: begin
        if (r_rx_cnt == CNT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_data_nxt  = r_rx_shift;
          w_rx_valid_nxt = 1'b1;
          w_rx_perr_nxt  = HAS_PAR && (r_rx_par_bit != ((^r_rx_shift) ^ ODD_PAR));
          w_rx_ferr_nxt  = !w_rx;
          w_rx_state_nxt = w_rx ? RXS_IDLE : RXS_WAIT_IDLE;
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_W'(1);
        end
      end
      RXS_WAIT_IDLE: begin
        if (w_rx) w_rx_state_nxt = RXS_IDLE;
      end
      default: w_rx_state_nxt = RXS_IDLE;
    endcase
  end

  assign RX_DATA       = r_rx_data;
  assign RX_VALID      = r_rx_valid;
  assign RX_PARITY_ERR = r_rx_perr;
  assign RX_FRAME_ERR  = r_rx_ferr;
  assign RX_BUSY       = (r_rx_state != RXS_IDLE);

endmodule

// File: tb/tb_uart_transceiver_param.sv
// Directed bench for uart_transceiver_param: DATA_W=8, CLKS_PER_BIT=4, even parity, one stop bit.
module tb_uart_transceiver_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_serial, tx_busy;
  logic       rx_serial, rx_valid, rx_perr, rx_ferr, rx_busy;
  logic [7:0] rx_data;
  logic       rx_sel, rx_drive;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rx_cnt;
  logic [7:0] rx_log [4];
  logic       perr_log [4];
  logic       ferr_log [4];
  logic       busy_seen;

  always #5 clk = ~clk;

  // Own TX can be looped back externally to RX for peer-to-peer scenarios.
  assign rx_serial = rx_sel ? tx_serial : rx_drive;

  uart_transceiver_param #(
    .DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)
  ) dut (
    .UART_CLK      (clk),
    .UART_RST_N    (rst_n),
    .TX_DATA       (tx_data),
    .TX_VALID      (tx_valid),
    .TX_READY      (tx_ready),
    .TX_SERIAL     (tx_serial),
    .TX_BUSY       (tx_busy),
`ifdef UART_LOOPBACK_EN
    .LOOPBACK      (1'b0),
`endif
    .RX_SERIAL     (rx_serial),
    .RX_DATA       (rx_data),
    .RX_VALID      (rx_valid),
    .RX_PARITY_ERR (rx_perr),
    .RX_FRAME_ERR  (rx_ferr),
    .RX_BUSY       (rx_busy)
  );

  // Advance one clock and sample 1 ns after the edge, logging any received word.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_valid) begin
      if (rx_cnt < 4) begin
        rx_log[rx_cnt]   = rx_data;
        perr_log[rx_cnt] = rx_perr;
        ferr_log[rx_cnt] = rx_ferr;
      end
      rx_cnt++;
    end
    if (rx_busy) busy_seen = 1'b1;
  endtask

  task automatic clear_log();
    rx_cnt    = 0;
    busy_seen = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic par_flip, input logic stop_val);
    logic [10:0] bits;
    bits = {stop_val, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drive = bits[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic test_reset();
    tx_data = 8'h00; tx_valid = 1'b0; rx_sel = 1'b0; rx_drive = 1'b1;
    clear_log();
    #22;
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL reset_tx_serial: got %b want 1", tx_serial); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_checks++; if (rx_perr !== 1'b0) begin n_fail++; $display("FAIL reset_rx_perr: got %b want 0", rx_perr); end
    n_checks++; if (rx_ferr !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ferr: got %b want 0", rx_ferr); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rx_busy: got %b want 0", rx_busy); end
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_tx_frame();
    logic [10:0] exp_bits;
    exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
    clear_log();
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_ready_idle: got %b want 1", tx_ready); end
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0; tx_data = 8'hFF;
    for (int c = 0; c < 44; c++) begin
      n_checks++;
      if (tx_serial !== exp_bits[c / CPB]) begin
        n_fail++; $display("FAIL tx_a5_bit cycle %0d: got %b want %b", c, tx_serial, exp_bits[c / CPB]);
      end
      n_checks++;
      if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL tx_a5_busy cycle %0d: got %b want 1", c, tx_busy); end
      tick();
    end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL tx_a5_busy_end: got %b want 0", tx_busy); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL tx_a5_ready_end: got %b want 1", tx_ready); end
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL tx_a5_idle_line: got %b want 1", tx_serial); end
    n_checks++; if (rx_cnt !== 0) begin n_fail++; $display("FAIL tx_a5_no_rx: got %0d words want 0", rx_cnt); end
  endtask

  task automatic test_back_to_back();
    rx_sel = 1'b1;
    clear_log();
    tx_data = 8'h3C; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    for (int c = 0; c < 150; c++) begin
      if (c == 43) begin
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_last_stop: got %b want 0", tx_ready); end
      end
      if (c == 44) begin
        n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_rise: got %b want 1", tx_ready); end
      end
      if (c == 45) begin
        n_checks++; if (tx_serial !== 1'b0) begin n_fail++; $display("FAIL b2b_second_start: got %b want 0", tx_serial); end
        tx_valid = 1'b0;
      end
      tick();
    end
    n_checks++; if (rx_cnt !== 2) begin n_fail++; $display("FAIL b2b_rx_count: got %0d want 2", rx_cnt); end
    n_checks++; if (rx_log[0] !== 8'h3C) begin n_fail++; $display("FAIL b2b_rx_word0: got %h want 3c", rx_log[0]); end
    n_checks++; if (rx_log[1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_rx_word1: got %h want ff", rx_log[1]); end
    n_checks++;
    if ({perr_log[0], ferr_log[0], perr_log[1], ferr_log[1]} !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_rx_errors: got %b%b%b%b want 0000", perr_log[0], ferr_log[0], perr_log[1], ferr_log[1]);
    end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_tx_done: got %b want 0", tx_busy); end
    rx_sel = 1'b0; rx_drive = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_parity_err();
    clear_log();
    send_rx(8'h81, 1'b1, 1'b1);
    repeat (8) tick();
    n_checks++; if (rx_cnt !== 1) begin n_fail++; $display("FAIL par_rx_count: got %0d want 1", rx_cnt); end
    n_checks++; if (rx_log[0] !== 8'h81) begin n_fail++; $display("FAIL par_rx_data: got %h want 81", rx_log[0]); end
    n_checks++; if (perr_log[0] !== 1'b1) begin n_fail++; $display("FAIL par_err_flag: got %b want 1", perr_log[0]); end
    n_checks++; if (ferr_log[0] !== 1'b0) begin n_fail++; $display("FAIL par_ferr_flag: got %b want 0", ferr_log[0]); end
    n_checks++; if (rx_perr !== 1'b1) begin n_fail++; $display("FAIL par_err_held: got %b want 1", rx_perr); end
    clear_log();
    send_rx(8'h55, 1'b0, 1'b1);
    repeat (8) tick();
    n_checks++; if (rx_cnt !== 1) begin n_fail++; $display("FAIL par_clean_count: got %0d want 1", rx_cnt); end
    n_checks++; if (rx_log[0] !== 8'h55) begin n_fail++; $display("FAIL par_clean_data: got %h want 55", rx_log[0]); end
    n_checks++; if (perr_log[0] !== 1'b0) begin n_fail++; $display("FAIL par_clean_cleared: got %b want 0", perr_log[0]); end
  endtask

  task automatic test_frame_err();
    clear_log();
    send_rx(8'h12, 1'b0, 1'b0);
    repeat (30) tick();
    n_checks++; if (rx_cnt !== 1) begin n_fail++; $display("FAIL ferr_rx_count: got %0d want 1", rx_cnt); end
    n_checks++; if (rx_log[0] !== 8'h12) begin n_fail++; $display("FAIL ferr_rx_data: got %h want 12", rx_log[0]); end
    n_checks++; if (ferr_log[0] !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", ferr_log[0]); end
    n_checks++; if (perr_log[0] !== 1'b0) begin n_fail++; $display("FAIL ferr_perr_flag: got %b want 0", perr_log[0]); end
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_in_break: got %b want 1", rx_busy); end
    rx_drive = 1'b1;
    repeat (8) tick();
    n_checks++; if (rx_cnt !== 1) begin n_fail++; $display("FAIL ferr_no_false_frame: got %0d want 1", rx_cnt); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_after_idle: got %b want 0", rx_busy); end
    n_checks++; if (rx_ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_flag_held: got %b want 1", rx_ferr); end
    clear_log();
    send_rx(8'h7E, 1'b0, 1'b1);
    repeat (8) tick();
    n_checks++; if (rx_cnt !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d want 1", rx_cnt); end
    n_checks++; if (rx_log[0] !== 8'h7E) begin n_fail++; $display("FAIL ferr_recover_data: got %h want 7e", rx_log[0]); end
    n_checks++; if (ferr_log[0] !== 1'b0) begin n_fail++; $display("FAIL ferr_recover_flag: got %b want 0", ferr_log[0]); end
  endtask

  task automatic test_glitch();
    clear_log();
    rx_drive = 1'b0;
    tick();
    rx_drive = 1'b1;
    repeat (20) tick();
    n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_seen: got %b want 1", busy_seen); end
    n_checks++; if (rx_cnt !== 0) begin n_fail++; $display("FAIL glitch_rx_valid: got %0d words want 0", rx_cnt); end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", rx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    rx_sel = 1'b1;
    clear_log();
    tx_data = 8'hC3; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (13) tick();
    n_checks++; if (tx_serial !== 1'b0) begin n_fail++; $display("FAIL rstmid_bit3_before: got %b want 0", tx_serial); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL rstmid_serial_forced: got %b want 1", tx_serial); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_cleared: got %b want 0", tx_busy); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b want 1", tx_ready); end
    repeat (4) tick();
    tx_data = 8'h96; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (60) tick();
    n_checks++; if (rx_cnt !== 1) begin n_fail++; $display("FAIL rstmid_rx_count: got %0d want 1", rx_cnt); end
    n_checks++; if (rx_log[0] !== 8'h96) begin n_fail++; $display("FAIL rstmid_next_frame: got %h want 96", rx_log[0]); end
    n_checks++;
    if ({perr_log[0], ferr_log[0]} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_next_errors: got %b%b want 00", perr_log[0], ferr_log[0]);
    end
    rx_sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_transceiver_param.md
Name: uart_transceiver_param

Overview:
Parametrised full-duplex UART transceiver. Successor to the fixed 8-bit, one-clock-per-bit UART pair; adds configurable width, baud divider, parity mode and stop bits, a valid/ready TX handshake, and mid-bit RX sampling with parity/framing error reporting. One instance per link endpoint; TX_SERIAL of one instance wires to RX_SERIAL of its peer.

Parameters:
DATA_W, 8, payload bits per frame (5..16)
CLKS_PER_BIT, 16, UART_CLK cycles per serial bit (>=4, even)
PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits transmitted (1 or 2)

Ports:
UART_CLK  in  1  single clock, all logic rising-edge
UART_RST_N  in  1  asynchronous reset, active low
TX_DATA  in  DATA_W  payload to send
TX_VALID  in  1  TX_DATA valid
TX_READY  out  1  transmitter can accept a word
TX_SERIAL  out  1  serial line out, idles high
TX_BUSY  out  1  frame in progress on TX_SERIAL
RX_SERIAL  in  1  serial line in, asynchronous
RX_DATA  out  DATA_W  last received payload
RX_VALID  out  1  one-cycle pulse, new RX_DATA
RX_PARITY_ERR  out  1  parity mismatch, qualified by RX_VALID
RX_FRAME_ERR  out  1  stop bit sampled low, qualified by RX_VALID
RX_BUSY  out  1  receiver inside a frame

Behaviour:
- Reset (async assert, sync deassert internally): TX_SERIAL=1, TX_READY=1, TX_BUSY=0, RX_DATA=0, RX_VALID=0, both error flags=0, RX_BUSY=0, both FSMs in IDLE, all counters 0, RX synchroniser flops=1.
- Frame: start(0), DATA_W data bits LSB first, parity bit if PARITY_MODE!=0, STOP_BITS stop bits(1). Frame length F = (1+DATA_W+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- Even parity: parity bit = XOR of data. Odd: its inverse.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped when none) -> STOP -> IDLE. Each bit held exactly CLKS_PER_BIT cycles by a bit-cycle counter; bit index counter counts 0..DATA_W-1.
- TX handshake: transfer when TX_VALID && TX_READY on a rising edge. TX_READY=1 only in IDLE. TX_DATA and parity latched at transfer; later TX_DATA changes ignored. Start bit appears on TX_SERIAL the cycle after transfer; TX_BUSY=1 from that cycle until the last stop-bit cycle inclusive.
- Back-to-back: TX_READY rises the cycle after the last stop cycle; with TX_VALID held, next start bit follows with zero idle bit-times.
- RX: RX_SERIAL passes a 2-flop synchroniser (2-cycle latency). IDLE: synchronised low -> START, RX_BUSY=1. START: after CLKS_PER_BIT/2 cycles resample; high = false start, return to IDLE with no RX_VALID; low -> DATA. DATA/PARITY/STOP: sample every CLKS_PER_BIT cycles (mid-bit). Only the first stop bit is checked.
- At stop-bit sample: RX_DATA updated, RX_VALID pulses one cycle, RX_PARITY_ERR/RX_FRAME_ERR set to the frame's result (held until next RX_VALID). PARITY_MODE=0: RX_PARITY_ERR always 0.
- Framing error: FSM enters WAIT_IDLE, stays until synchronised line is high, then IDLE (no false frame on a break). Otherwise IDLE directly after the stop sample; RX_BUSY drops the same cycle.
- TX and RX fully independent; simultaneous TX transfer and RX_VALID permitted.
- Reset mid-frame: TX_SERIAL forced to 1 immediately, in-flight TX word and partial RX word discarded; no RX_VALID.

Optional Feature:
UART_LOOPBACK_EN: when defined, adds input port LOOPBACK (1 bit); LOOPBACK=1 routes the internal TX serial bit into the RX synchroniser in place of RX_SERIAL and holds TX_SERIAL=1. Without the macro the port does not exist and RX always uses RX_SERIAL.

Test Plan:
- DATA_W=8, CLKS_PER_BIT=4, even parity: send 0xA5 -> TX_SERIAL 0,1,0,1,0,0,1,0,1,0(parity),1, each 4 cycles; TX_BUSY high 44 cycles.
- Peer TX->RX of 0x3C then 0xFF back-to-back, TX_VALID held -> no idle gap; RX_VALID twice, RX_DATA=0x3C then 0xFF, no errors.
- Inject 0x81 with parity bit inverted -> RX_VALID with RX_DATA=0x81, RX_PARITY_ERR=1; next clean frame clears it.
- Stop bit driven 0, line held low 30 cycles -> RX_FRAME_ERR=1, no further RX_VALID until line high and new start.
- 1-cycle low glitch on RX_SERIAL -> false start rejected, RX_VALID stays 0, RX_BUSY returns 0.
- UART_RST_N asserted at bit 3 of a TX frame -> TX_SERIAL=1 same cycle, TX_READY=1 after release, next frame correct.
